// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetches a 9-bit instruction, decodes it and walks
// EXEC/MEM/WB while driving the datapath source-select muxes and write enables.
module ctrl_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [8:0]       instr,
    input  logic             zero_flag,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             format,
    output logic             Load,
    output logic             ALUSrc,
    output logic             Branch,
    output logic             Copy,
    output logic             Move,
    output logic             BranchResult,
    output logic             reg_we,
    output logic             pc_en,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired_cnt
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // FETCH  | imem_req high, waiting for imem_ack
    // DECODE | latched opcode drives the select registers
    // EXEC   | one ALU cycle; BEQ samples zero_flag
    // MEM    | dmem_req high, waiting for dmem_ack with timeout
    // WB     | reg_we/pc_en pulse, retire count
    // DONE   | HALT reached, start restarts fetching
    // ERROR  | memory timeout, left only by Reset
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_ST   = 3'b011;
    localparam logic [2:0] OP_CPY  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] MEM_LAST = TW'(MEM_TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    op_q;
    logic [TW-1:0] mem_cnt;
    logic          writes_reg;
    logic          unused_operand;

    // Operand bits feed the datapath directly; only the opcode matters here.
    assign unused_operand = ^instr[5:0];

    assign writes_reg = (op_q == OP_ADD) || (op_q == OP_ADDI) || (op_q == OP_LD) ||
                        (op_q == OP_CPY) || (op_q == OP_MOV);

    // Decoded from state so an async Reset drops them in the same cycle.
    assign imem_req = (state == S_FETCH);
    assign dmem_req = (state == S_MEM);
    assign dmem_we  = (state == S_MEM) && (op_q == OP_ST);
    assign reg_we   = (state == S_WB) && writes_reg;
    assign pc_en    = (state == S_WB);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERROR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            mem_cnt      <= '0;
            retired_cnt  <= '0;
            format       <= 1'b0;
            Load         <= 1'b0;
            ALUSrc       <= 1'b0;
            Branch       <= 1'b0;
            Copy         <= 1'b0;
            Move         <= 1'b0;
            BranchResult <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        op_q  <= instr[8:6];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    format       <= (op_q == OP_ADDI);
                    Load         <= (op_q == OP_LD);
                    ALUSrc       <= (op_q == OP_ADDI) || (op_q == OP_LD) || (op_q == OP_ST);
                    Branch       <= (op_q == OP_BEQ);
                    Copy         <= (op_q == OP_CPY);
                    Move         <= (op_q == OP_MOV);
                    BranchResult <= 1'b0;
                    state        <= (op_q == OP_HALT) ? S_DONE : S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_BEQ) BranchResult <= zero_flag;
                    mem_cnt <= '0;
                    state   <= ((op_q == OP_LD) || (op_q == OP_ST)) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    // An ack on the final allowed cycle beats the timeout.
                    if (dmem_ack)                 state   <= S_WB;
                    else if (mem_cnt == MEM_LAST) state   <= S_ERROR;
                    else                          mem_cnt <= mem_cnt + 1'b1;
                end
                S_WB: begin
                    if (retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
                    format       <= 1'b0;
                    Load         <= 1'b0;
                    ALUSrc       <= 1'b0;
                    Branch       <= 1'b0;
                    Copy         <= 1'b0;
                    Move         <= 1'b0;
                    BranchResult <= 1'b0;
                    state        <= S_FETCH;
                end
                S_DONE: begin
                    if (start) state <= S_FETCH;
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: instruction walks, memory wait/timeout,
// HALT/restart and asynchronous reset during a store.
module tb_ctrl_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        imem_req;
    logic        imem_ack;
    logic [8:0]  instr;
    logic        zero_flag;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        format, Load, ALUSrc, Branch, Copy, Move, BranchResult;
    logic        reg_we, pc_en, done, err;
    logic [15:0] retired_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    ctrl_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .zero_flag(zero_flag),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .format(format), .Load(Load), .ALUSrc(ALUSrc), .Branch(Branch),
        .Copy(Copy), .Move(Move), .BranchResult(BranchResult),
        .reg_we(reg_we), .pc_en(pc_en), .done(done), .err(err),
        .retired_cnt(retired_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [6:0] sels();
        return {format, Load, ALUSrc, Branch, Copy, Move, BranchResult};
    endfunction

    // Starts in FETCH; runs a non-memory instruction through WB and back to FETCH.
    task automatic run_short(input string tag, input logic [8:0] ins, input logic zf,
                             input logic [6:0] sel, input logic rw);
        chk({tag, "_fetch_req"}, imem_req, 1);
        instr = ins; imem_ack = 1'b1;
        tick();                                   // DECODE
        imem_ack = 1'b0; instr = 9'h1ff;
        chk({tag, "_dec_sel"}, sels(), 0);
        zero_flag = zf;
        tick();                                   // EXEC
        chk({tag, "_exec_sel"}, sels(), {sel[6:1], 1'b0});
        chk({tag, "_exec_we"}, {reg_we, pc_en}, 0);
        tick();                                   // WB
        zero_flag = ~zf;
        chk({tag, "_wb_sel"}, sels(), sel);
        chk({tag, "_wb_reg_we"}, reg_we, rw);
        chk({tag, "_wb_pc_en"}, pc_en, 1);
        tick();                                   // FETCH again: 4 cycles total
        exp_cnt++;
        chk({tag, "_cnt"}, retired_cnt, exp_cnt);
        chk({tag, "_cleared"}, {sels(), reg_we, pc_en}, 0);
        chk({tag, "_refetch"}, imem_req, 1);
    endtask

    // Starts in FETCH; ends in the first MEM cycle.
    task automatic enter_mem(input logic [8:0] ins);
        instr = ins; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int req_cycles;
        Reset = 1'b1; start = 1'b0; imem_ack = 1'b0; instr = '0;
        zero_flag = 1'b0; dmem_ack = 1'b0;
        tick(); tick();
        chk("rst_outputs", {imem_req, dmem_req, dmem_we, sels(), reg_we, pc_en, done, err}, 0);
        chk("rst_cnt", retired_cnt, 0);
        Reset = 1'b0;
        tick();
        chk("idle_no_start", imem_req, 0);
        start = 1'b1;
        tick();
        start = 1'b0;

        run_short("addi", 9'b001_000101, 1'b0, 7'b1010000, 1'b1);
        run_short("beq_t", 9'b110_000011, 1'b1, 7'b0001001, 1'b0);
        run_short("beq_nt", 9'b110_000011, 1'b0, 7'b0001000, 1'b0);
        run_short("add", 9'b000_010010, 1'b1, 7'b0000000, 1'b1);
        run_short("cpy", 9'b100_000001, 1'b0, 7'b0000100, 1'b1);
        run_short("mov", 9'b101_111111, 1'b0, 7'b0000010, 1'b1);

        // LD, ack after 3 wait cycles
        enter_mem(9'b010_000001);
        chk("ld_mem_sel", sels(), 7'b0110000);
        chk("ld_mem_we", dmem_we, 0);
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (dmem_req) req_cycles++;
            dmem_ack = (i == 3);
            tick();
        end
        dmem_ack = 1'b0;
        chk("ld_req_cycles", req_cycles, 4);
        chk("ld_wb", {dmem_req, reg_we, pc_en, Load}, 4'b0111);
        tick();
        exp_cnt++;
        chk("ld_after_wb", {reg_we, imem_req}, 2'b01);
        chk("ld_cnt", retired_cnt, exp_cnt);

        // ST, immediate ack
        enter_mem(9'b011_000100);
        chk("st_mem", {dmem_req, dmem_we, ALUSrc}, 3'b111);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("st_wb", {dmem_req, dmem_we, reg_we, pc_en}, 4'b0001);
        tick();
        exp_cnt++;
        chk("st_cnt", retired_cnt, exp_cnt);

        // HALT then restart
        instr = 9'b111_000000; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("halt_done", {done, pc_en, reg_we, imem_req}, 4'b1000);
        tick();
        chk("halt_hold", done, 1);
        chk("halt_cnt", retired_cnt, exp_cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart", {done, imem_req}, 2'b01);

        // LD with ack on the last allowed MEM cycle
        enter_mem(9'b010_000010);
        for (int i = 0; i < 15; i++) tick();
        chk("edge_still_mem", {dmem_req, err}, 2'b10);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("edge_ack_wins", {err, reg_we, pc_en}, 3'b011);
        tick();
        exp_cnt++;
        chk("edge_cnt", retired_cnt, exp_cnt);

        // LD with no ack -> ERROR after 16 MEM cycles
        enter_mem(9'b010_000011);
        for (int i = 0; i < 15; i++) tick();
        chk("to_cycle16", {dmem_req, err}, 2'b10);
        tick();
        chk("to_err", {dmem_req, err, reg_we, pc_en}, 4'b0100);
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        chk("err_sticky", {err, imem_req}, 2'b10);
        chk("err_cnt", retired_cnt, exp_cnt);

        // Reset during MEM of ST
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("err_cleared", err, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        enter_mem(9'b011_000000);
        chk("rst_st_mem", {dmem_req, dmem_we}, 2'b11);
        #2 Reset = 1'b1;
        #1;
        chk("rst_async", {dmem_req, dmem_we, reg_we, pc_en, sels()}, 0);
        chk("rst_async_cnt", retired_cnt, 0);
        tick();
        Reset = 1'b0;
        tick();
        chk("rst_idle", {imem_req, dmem_req, done, err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
